wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/pipeline_pkg.sv | 32 +++
 rtl/wb_stage_if.sv | 33 +++
 rtl/wb_stage_load_ext.sv | 51 +++++
 rtl/wb_stage.sv | 98 +++++++++
 tb/tb_wb_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: writeback source selects, load types and the
// packed layout of the writeback register.
package pipeline_pkg;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_ALU2 = 2'b11;

    // Load type (bmask); any other code behaves as a word load
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Contents of the WB pipeline register; all-zero is a bubble
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_wren;
        logic        ld_misalign;
    } wb_reg_t;

    // Return address for link instructions; wraps naturally at 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundles the MEM->WB inputs and the registered writeback/forwarding bus.
// The driver side (MEM stage or a bench) uses master; the WB stage side uses slave.
interface wb_stage_if;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_data;
    logic [31:0] ld_data;
    logic [1:0]  lsu_addr_lo;
    logic [2:0]  bmask;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        wb_rd_wren;
    logic        wb_valid;
    logic        ld_misalign;
    logic [31:0] instret;

    modport master (
        output stall, flush, valid, pc, alu_data, ld_data, lsu_addr_lo,
               bmask, wb_sel, rd_addr, rd_wren,
        input  wb_rd_addr, wb_rd_data, wb_rd_wren, wb_valid, ld_misalign, instret
    );

    modport slave (
        input  stall, flush, valid, pc, alu_data, ld_data, lsu_addr_lo,
               bmask, wb_sel, rd_addr, rd_wren,
        output wb_rd_addr, wb_rd_data, wb_rd_wren, wb_valid, ld_misalign, instret
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Combinational load formatter: picks the byte/halfword addressed by the low
// address bits, extends it to 32 bits and reports misaligned halfword/word loads.
import pipeline_pkg::*;

module load_ext (
    input  logic [31:0] ld_data,
    input  logic [1:0]  off,
    input  logic [2:0]  bmask,
    output logic [31:0] data,
    output logic        misalign
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and sign/zero extension per load type
    always_comb begin
        byte_sel = ld_data[7:0];
        case (off)
            2'd0: byte_sel = ld_data[7:0];
            2'd1: byte_sel = ld_data[15:8];
            2'd2: byte_sel = ld_data[23:16];
            2'd3: byte_sel = ld_data[31:24];
            default: byte_sel = ld_data[7:0];
        endcase
        half_sel = off[1] ? ld_data[31:16] : ld_data[15:0];

        data     = ld_data;
        misalign = 1'b0;
        case (bmask)
            LD_LB: begin
                data = {{24{byte_sel[7]}}, byte_sel};
            end
            LD_LBU: begin
                data = {24'd0, byte_sel};
            end
            LD_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = off[0];
            end
            LD_LHU: begin
                data     = {16'd0, half_sel};
                misalign = off[0];
            end
            // LW and the undefined codes all load the full word
            default: begin
                data     = ld_data;
                misalign = (off != 2'd0);
            end
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 data from the MEM stage, registers
// it as the writeback and forwarding bus, and counts retired instructions.
import pipeline_pkg::*;

module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_alu_data,
    input  logic [31:0]      i_ld_data,
    input  logic [1:0]       i_lsu_addr_lo,
    input  logic [2:0]       i_bmask,
    input  logic [1:0]       i_wb_sel,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_wren,
    output logic [4:0]       o_rd_addr,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_wren,
    output logic             o_valid,
    output logic             o_ld_misalign,
    output logic [CNT_W-1:0] o_instret
);
    logic [31:0]      ld_ext_data;
    logic             ld_ext_misalign;
    logic [31:0]      wb_data;
    logic             load_misalign;
    wb_reg_t          capture;
    wb_reg_t          wb_reg;
    wb_reg_t          wb_next;
    logic [CNT_W-1:0] instret_reg;
    logic [CNT_W-1:0] instret_next;

    load_ext u_load_ext (
        .ld_data  (i_ld_data),
        .off      (i_lsu_addr_lo),
        .bmask    (i_bmask),
        .data     (ld_ext_data),
        .misalign (ld_ext_misalign)
    );

    // Writeback data mux and the register image of the incoming instruction
    always_comb begin
        case (i_wb_sel)
            WB_SEL_LOAD: wb_data = ld_ext_data;
            WB_SEL_PC4:  wb_data = pc_plus4(i_pc);
            default:     wb_data = i_alu_data;
        endcase
        // Misalignment only matters when the load result is actually used
        load_misalign = (i_wb_sel == WB_SEL_LOAD) && ld_ext_misalign;

        capture = '0;
        if (i_valid) begin
            capture.valid       = 1'b1;
            capture.rd_addr     = i_rd_addr;
            capture.rd_data     = wb_data;
            capture.ld_misalign = load_misalign;
            // x0 is never written and a faulting load must not update rd
            capture.rd_wren     = i_rd_wren && (i_rd_addr != 5'd0) && !load_misalign;
        end
    end

    // Flush beats stall; a stall freezes both the register and the counter
    always_comb begin
        wb_next      = wb_reg;
        instret_next = instret_reg;
        if (i_flush) begin
            wb_next = '0;
        end else if (!i_stall) begin
            wb_next = capture;
            if (i_valid) begin
                instret_next = instret_reg + CNT_W'(1);
            end
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wb_reg      <= '0;
            instret_reg <= '0;
        end else begin
            wb_reg      <= wb_next;
            instret_reg <= instret_next;
        end
    end

    assign o_valid       = wb_reg.valid;
    assign o_rd_addr     = wb_reg.rd_addr;
    assign o_rd_data     = wb_reg.rd_data;
    assign o_rd_wren     = wb_reg.rd_wren;
    assign o_ld_misalign = wb_reg.ld_misalign;
    assign o_instret     = instret_reg;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load formatting, PC+4 wrap, stall/flush,
// counter wrap (4-bit instance) and asynchronous reset.
import pipeline_pkg::*;

module tb_wb_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] exp_instret;

    wb_stage_if bus ();

    // Outputs of the narrow-counter instance
    logic [4:0]  s_rd_addr;
    logic [31:0] s_rd_data;
    logic        s_rd_wren;
    logic        s_valid;
    logic        s_ld_misalign;
    logic [3:0]  s_instret;

    wb_stage dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_stall(bus.stall), .i_flush(bus.flush), .i_valid(bus.valid),
        .i_pc(bus.pc), .i_alu_data(bus.alu_data), .i_ld_data(bus.ld_data),
        .i_lsu_addr_lo(bus.lsu_addr_lo), .i_bmask(bus.bmask), .i_wb_sel(bus.wb_sel),
        .i_rd_addr(bus.rd_addr), .i_rd_wren(bus.rd_wren),
        .o_rd_addr(bus.wb_rd_addr), .o_rd_data(bus.wb_rd_data), .o_rd_wren(bus.wb_rd_wren),
        .o_valid(bus.wb_valid), .o_ld_misalign(bus.ld_misalign), .o_instret(bus.instret)
    );

    wb_stage #(.CNT_W(4)) dut_small (
        .i_clk(clk), .i_reset(rst_n),
        .i_stall(bus.stall), .i_flush(bus.flush), .i_valid(bus.valid),
        .i_pc(bus.pc), .i_alu_data(bus.alu_data), .i_ld_data(bus.ld_data),
        .i_lsu_addr_lo(bus.lsu_addr_lo), .i_bmask(bus.bmask), .i_wb_sel(bus.wb_sel),
        .i_rd_addr(bus.rd_addr), .i_rd_wren(bus.rd_wren),
        .o_rd_addr(s_rd_addr), .o_rd_data(s_rd_data), .o_rd_wren(s_rd_wren),
        .o_valid(s_valid), .o_ld_misalign(s_ld_misalign), .o_instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set MEM-stage inputs (stall/flush left to the caller)
    task automatic drive(input logic valid, input logic [1:0] wb_sel, input logic [2:0] bmask,
                         input logic [1:0] off, input logic [31:0] ld_data,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rd_wren);
        bus.valid       = valid;
        bus.wb_sel      = wb_sel;
        bus.bmask       = bmask;
        bus.lsu_addr_lo = off;
        bus.ld_data     = ld_data;
        bus.alu_data    = alu;
        bus.pc          = pc;
        bus.rd_addr     = rd;
        bus.rd_wren     = rd_wren;
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and restart the expected counter
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_instret = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h12345678, 32'h0, 5'd3, 1'b1);
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_rd_wren, bus.ld_misalign, bus.wb_rd_addr, bus.wb_rd_data} !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b wren=%b mis=%b addr=%0d data=%h want all 0",
                     bus.wb_valid, bus.wb_rd_wren, bus.ld_misalign, bus.wb_rd_addr, bus.wb_rd_data);
        end
        checks++;
        if (bus.instret !== 32'd0 || s_instret !== 4'd0) begin
            failures++;
            $display("FAIL reset_instret got %0d/%0d want 0/0", bus.instret, s_instret);
        end
        $display("txn reset: valid=%b instret=%0d", bus.wb_valid, bus.instret);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
    endtask

    task automatic test_loads();
        // LB byte 2 of 0x12F45678 = 0xF4, sign-extended
        drive(1'b1, WB_SEL_LOAD, LD_LB, 2'd2, 32'h12F45678, 32'h0, 32'h0, 5'd5, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'hFFFFFFF4 || bus.wb_rd_wren !== 1'b1 || bus.wb_rd_addr !== 5'd5) begin
            failures++;
            $display("FAIL lb_off2 got data=%h wren=%b addr=%0d want FFFFFFF4/1/5",
                     bus.wb_rd_data, bus.wb_rd_wren, bus.wb_rd_addr);
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL lb_instret got %0d want %0d", bus.instret, exp_instret);
        end
        $display("txn LB: data=%h instret=%0d", bus.wb_rd_data, bus.instret);

        // LHU upper half of 0x8001ABCD
        drive(1'b1, WB_SEL_LOAD, LD_LHU, 2'd2, 32'h8001ABCD, 32'h0, 32'h0, 5'd6, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'h00008001 || bus.ld_misalign !== 1'b0) begin
            failures++;
            $display("FAIL lhu_off2 got data=%h mis=%b want 00008001/0", bus.wb_rd_data, bus.ld_misalign);
        end
        $display("txn LHU: data=%h", bus.wb_rd_data);

        // LH at odd offset: misaligned, no write, still retired
        drive(1'b1, WB_SEL_LOAD, LD_LH, 2'd1, 32'h8001ABCD, 32'h0, 32'h0, 5'd6, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.ld_misalign !== 1'b1 || bus.wb_rd_wren !== 1'b0 || bus.wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL lh_misalign got mis=%b wren=%b valid=%b want 1/0/1",
                     bus.ld_misalign, bus.wb_rd_wren, bus.wb_valid);
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL lh_misalign_instret got %0d want %0d", bus.instret, exp_instret);
        end
        $display("txn LH misaligned: mis=%b instret=%0d", bus.ld_misalign, bus.instret);

        // LH low half sign-extended; misalign flag cleared again
        drive(1'b1, WB_SEL_LOAD, LD_LH, 2'd0, 32'h8001ABCD, 32'h0, 32'h0, 5'd7, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'hFFFFABCD || bus.ld_misalign !== 1'b0 || bus.wb_rd_wren !== 1'b1) begin
            failures++;
            $display("FAIL lh_off0 got data=%h mis=%b wren=%b want FFFFABCD/0/1",
                     bus.wb_rd_data, bus.ld_misalign, bus.wb_rd_wren);
        end

        // LBU top byte zero-extended
        drive(1'b1, WB_SEL_LOAD, LD_LBU, 2'd3, 32'h8001ABCD, 32'h0, 32'h0, 5'd8, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_off3 got data=%h want 00000080", bus.wb_rd_data);
        end

        // LW with nonzero offset is misaligned
        drive(1'b1, WB_SEL_LOAD, LD_LW, 2'd2, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.ld_misalign !== 1'b1 || bus.wb_rd_wren !== 1'b0) begin
            failures++;
            $display("FAIL lw_misalign got mis=%b wren=%b want 1/0", bus.ld_misalign, bus.wb_rd_wren);
        end

        // Undefined code 011 behaves as an aligned LW
        drive(1'b1, WB_SEL_LOAD, 3'b011, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'hCAFEF00D || bus.ld_misalign !== 1'b0 || bus.wb_rd_wren !== 1'b1) begin
            failures++;
            $display("FAIL bmask011_as_lw got data=%h mis=%b wren=%b want CAFEF00D/0/1",
                     bus.wb_rd_data, bus.ld_misalign, bus.wb_rd_wren);
        end

        // Misaligned offset ignored when the ALU result is selected
        drive(1'b1, WB_SEL_ALU2, LD_LW, 2'd3, 32'hCAFEF00D, 32'h13572468, 32'h0, 5'd10, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'h13572468 || bus.ld_misalign !== 1'b0 || bus.wb_rd_wren !== 1'b1) begin
            failures++;
            $display("FAIL alu_sel11 got data=%h mis=%b wren=%b want 13572468/0/1",
                     bus.wb_rd_data, bus.ld_misalign, bus.wb_rd_wren);
        end
        $display("txn ALU sel11: data=%h instret=%0d", bus.wb_rd_data, bus.instret);
    endtask

    task automatic test_pc4();
        drive(1'b1, WB_SEL_PC4, LD_LW, 2'd0, 32'h0, 32'hAAAA5555, 32'hFFFFFFFC, 5'd1, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'h00000000 || bus.wb_rd_wren !== 1'b1 || bus.wb_rd_addr !== 5'd1) begin
            failures++;
            $display("FAIL pc4_wrap got data=%h wren=%b addr=%0d want 00000000/1/1",
                     bus.wb_rd_data, bus.wb_rd_wren, bus.wb_rd_addr);
        end
        $display("txn PC+4 wrap: data=%h", bus.wb_rd_data);

        drive(1'b1, WB_SEL_PC4, LD_LW, 2'd0, 32'h0, 32'h0, 32'h00001000, 5'd0, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_wren !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_rd_data !== 32'h00001004) begin
            failures++;
            $display("FAIL rd_x0 got wren=%b valid=%b data=%h want 0/1/00001004",
                     bus.wb_rd_wren, bus.wb_valid, bus.wb_rd_data);
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL rd_x0_instret got %0d want %0d", bus.instret, exp_instret);
        end
        $display("txn rd=x0: wren=%b instret=%0d", bus.wb_rd_wren, bus.instret);
    endtask

    task automatic test_stall_flush();
        drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd12, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_rd_data !== 32'hDEADBEEF || bus.wb_rd_addr !== 5'd12) begin
            failures++;
            $display("FAIL stall_capture got data=%h addr=%0d want DEADBEEF/12", bus.wb_rd_data, bus.wb_rd_addr);
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h1111_0000 + i, 32'h0, 5'd20 + 5'(i), 1'b1);
            tick();
            checks++;
            if (bus.wb_rd_data !== 32'hDEADBEEF || bus.wb_rd_addr !== 5'd12 || bus.wb_rd_wren !== 1'b1
                || bus.wb_valid !== 1'b1 || bus.instret !== exp_instret) begin
                failures++;
                $display("FAIL stall_hold%0d got data=%h addr=%0d wren=%b valid=%b instret=%0d want DEADBEEF/12/1/1/%0d",
                         i, bus.wb_rd_data, bus.wb_rd_addr, bus.wb_rd_wren, bus.wb_valid, bus.instret, exp_instret);
            end
            $display("txn stall %0d: data=%h instret=%0d", i, bus.wb_rd_data, bus.instret);
        end
        bus.flush = 1'b1;
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_rd_wren, bus.ld_misalign, bus.wb_rd_addr, bus.wb_rd_data} !== 40'd0
            || bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL stall_flush_bubble got valid=%b wren=%b data=%h instret=%0d want 0/0/0/%0d",
                     bus.wb_valid, bus.wb_rd_wren, bus.wb_rd_data, bus.instret, exp_instret);
        end
        $display("txn stall+flush: valid=%b instret=%0d", bus.wb_valid, bus.instret);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Invalid instruction captures a bubble without retiring
        drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h55555555, 32'h0, 5'd4, 1'b1);
        tick(); exp_instret++;
        drive(1'b0, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h77777777, 32'h0, 5'd4, 1'b1);
        tick();
        checks++;
        if ({bus.wb_valid, bus.wb_rd_wren, bus.wb_rd_addr, bus.wb_rd_data} !== 39'd0
            || bus.instret !== exp_instret) begin
            failures++;
            $display("FAIL invalid_bubble got valid=%b wren=%b data=%h instret=%0d want 0/0/0/%0d",
                     bus.wb_valid, bus.wb_rd_wren, bus.wb_rd_data, bus.instret, exp_instret);
        end
        $display("txn invalid: valid=%b instret=%0d", bus.wb_valid, bus.instret);
    endtask

    task automatic test_counter_wrap();
        pulse_reset();
        drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h00000042, 32'h0, 5'd2, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(); exp_instret++;
        end
        checks++;
        if (s_instret !== 4'd15 || bus.instret !== 32'd15) begin
            failures++;
            $display("FAIL wrap_15 got small=%0d wide=%0d want 15/15", s_instret, bus.instret);
        end
        $display("txn 15 captures: small=%0d wide=%0d", s_instret, bus.instret);
        tick(); exp_instret++;
        checks++;
        if (s_instret !== 4'd0 || bus.instret !== 32'd16) begin
            failures++;
            $display("FAIL wrap_16 got small=%0d wide=%0d want 0/16", s_instret, bus.instret);
        end
        $display("txn 16th capture: small=%0d wide=%0d", s_instret, bus.instret);
    endtask

    task automatic test_async_reset();
        drive(1'b1, WB_SEL_ALU, LD_LW, 2'd0, 32'h0, 32'h11112222, 32'h0, 5'd3, 1'b1);
        tick(); exp_instret++;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd_data !== 32'h11112222) begin
            failures++;
            $display("FAIL pre_reset got valid=%b data=%h want 1/11112222", bus.wb_valid, bus.wb_rd_data);
        end
        // Assert mid-cycle, well before the next rising edge
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.wb_valid, bus.wb_rd_wren, bus.ld_misalign, bus.wb_rd_addr, bus.wb_rd_data} !== 40'd0
            || bus.instret !== 32'd0 || s_instret !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%b wren=%b data=%h instret=%0d small=%0d want all 0",
                     bus.wb_valid, bus.wb_rd_wren, bus.wb_rd_data, bus.instret, s_instret);
        end
        // An edge during reset must not capture the held valid input
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_held got valid=%b instret=%0d want 0/0", bus.wb_valid, bus.instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
        tick(); exp_instret++;
        checks++;
        if (bus.instret !== 32'd1 || bus.wb_rd_data !== 32'h11112222 || bus.wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got instret=%0d data=%h valid=%b want 1/11112222/1",
                     bus.instret, bus.wb_rd_data, bus.wb_valid);
        end
        $display("txn post-reset: instret=%0d data=%h", bus.instret, bus.wb_rd_data);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_instret = 0;
        test_reset();
        test_loads();
        test_pc4();
        test_stall_flush();
        test_counter_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
